// File: rtl/picorv32_wb_bridge_pkg.sv
// Shared types and defaults for the PicoRV32 to Wishbone B4 pipelined bridge.
package picorv32_wb_bridge_pkg;

   localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
   localparam logic [31:0] ERR_RDATA_DEF      = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } bridge_state_e;

   // Reads fetch the whole word; writes select only the strobed lanes.
   function automatic logic [3:0] wb_sel_for(input logic [3:0] wstrb);
      return (|wstrb) ? wstrb : 4'hF;
   endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Cycle counter guarding one bus transfer; flags the last allowed cycle.
module wb_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned     CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Clear on a new transfer, otherwise count while the transfer is outstanding.
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_enable) begin
         count_d = count_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_expired = i_enable && (count_q == LAST);

endmodule

// File: rtl/picorv32_wb_bridge.sv
// PicoRV32 native memory port to Wishbone B4 pipelined single-beat master.
//
//  state | meaning
//  IDLE  | no transfer; waiting for mem_valid
//  REQ   | cyc=stb=1, waiting for the slave to stop stalling
//  WAIT  | request accepted, cyc=1 stb=0, waiting for ack/err
//  RESP  | cyc=0, mem_ready pulse to the core
module picorv32_wb_bridge
   import picorv32_wb_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_mem_valid,
   input  logic        i_mem_instr,
   input  logic [31:0] i_mem_addr,
   input  logic [31:0] i_mem_wdata,
   input  logic [3:0]  i_mem_wstrb,
   output logic        o_mem_ready,
   output logic [31:0] o_mem_rdata,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_wb_sel,
   input  logic        i_wb_ack,
   input  logic [31:0] i_wb_data,
   input  logic        i_wb_stall,
   input  logic        i_wb_err,
   output logic        o_bus_err
);

   bridge_state_e state_q, state_d;
   logic          cyc_q, cyc_d;
   logic          stb_q, stb_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic [3:0]    sel_q, sel_d;
   logic          ready_q, ready_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          bus_err_q, bus_err_d;

   logic          xfer_done;
   logic          xfer_fail;
   logic          tmo_clear;
   logic          tmo_enable;
   logic          tmo_expired;

   // Instruction fetches share the data path, so the flag carries no information here.
   logic          unused_instr;
   assign unused_instr = i_mem_instr;

   // Counter runs only while the bus is owned; kept off the FSM block to avoid a comb loop.
   assign tmo_clear  = (state_q == IDLE) && i_mem_valid;
   assign tmo_enable = (state_q == REQ) || (state_q == WAIT);

   wb_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (tmo_clear),
      .i_enable  (tmo_enable),
      .o_expired (tmo_expired)
   );

   // Next-state and next-output logic; every output is registered.
   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      we_d      = we_q;
      addr_d    = addr_q;
      data_d    = data_q;
      sel_d     = sel_q;
      ready_d   = 1'b0;
      rdata_d   = rdata_q;
      bus_err_d = bus_err_q;
      xfer_done = 1'b0;
      xfer_fail = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_mem_valid) begin
               state_d = REQ;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = |i_mem_wstrb;
               sel_d   = wb_sel_for(i_mem_wstrb);
               addr_d  = i_mem_addr;
               data_d  = i_mem_wdata;
            end
         end
         REQ: begin
            // ack/err during a stall belong to nothing we issued and are ignored.
            if (!i_wb_stall) begin
               stb_d = 1'b0;
               if (i_wb_err) begin
                  xfer_fail = 1'b1;
               end else if (i_wb_ack) begin
                  xfer_done = 1'b1;
               end else if (tmo_expired) begin
                  xfer_fail = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end else if (tmo_expired) begin
               xfer_fail = 1'b1;
            end
         end
         WAIT: begin
            if (i_wb_err) begin
               xfer_fail = 1'b1;
            end else if (i_wb_ack) begin
               xfer_done = 1'b1;
            end else if (tmo_expired) begin
               xfer_fail = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
      endcase

      if (xfer_done || xfer_fail) begin
         state_d = RESP;
         cyc_d   = 1'b0;
         stb_d   = 1'b0;
         ready_d = 1'b1;
      end

      if (xfer_fail) begin
         rdata_d   = ERR_RDATA;
         bus_err_d = 1'b1;
      end else if (xfer_done && !we_q) begin
         rdata_d = i_wb_data;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= IDLE;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         sel_q     <= '0;
         ready_q   <= 1'b0;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         sel_q     <= sel_d;
         ready_q   <= ready_d;
         rdata_q   <= rdata_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign o_mem_ready = ready_q;
   assign o_mem_rdata = rdata_q;
   assign o_wb_cyc    = cyc_q;
   assign o_wb_stb    = stb_q;
   assign o_wb_we     = we_q;
   assign o_wb_addr   = addr_q;
   assign o_wb_data   = data_q;
   assign o_wb_sel    = sel_q;
   assign o_bus_err   = bus_err_q;

`ifdef FORMAL
   logic [16:0] cyc_len_q;

   // Length of the current bus cycle, for the ownership bound below.
   always_ff @(posedge i_clk) begin
      if (i_reset || !cyc_q) begin
         cyc_len_q <= '0;
      end else begin
         cyc_len_q <= cyc_len_q + 17'd1;
      end
   end

   a_stb_in_cyc: assert property (@(posedge i_clk) disable iff (i_reset) stb_q |-> cyc_q);
   a_ready_pulse: assert property (@(posedge i_clk) disable iff (i_reset) ready_q |=> !ready_q);
   a_cyc_bound: assert property (@(posedge i_clk) disable iff (i_reset)
                                 cyc_len_q <= 17'(TIMEOUT_CYCLES + 1));
`endif

endmodule
